// File: rtl/fm_sweep_controller.sv
// Linear carrier-frequency sweep sequencer for the FM generator: loads a start
// increment, dwells a programmed number of i_ce ticks per point, steps toward the stop.
module fm_sweep_controller #(
  parameter int unsigned accumulator_width = 32,
  parameter int unsigned sine_lookup_width = 16,
  parameter int unsigned dwell_width       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_reset_n,
  input  logic                         i_ce,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic                         i_loop,
  input  logic [accumulator_width-2:0] i_start_inc,
  input  logic [accumulator_width-2:0] i_stop_inc,
  input  logic [accumulator_width-2:0] i_step_inc,
  input  logic [dwell_width-1:0]       i_dwell,
  input  logic [accumulator_width-2:0] i_mod_inc,
  input  logic [sine_lookup_width:0]   i_dev,
  output logic [accumulator_width-2:0] o_carrier_center_increment,
  output logic [accumulator_width-2:0] o_modulation_increment,
  output logic [sine_lookup_width:0]   o_modulation_deviation_amount,
  output logic                         o_update,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [dwell_width-1:0]       o_step_count
);

  localparam int unsigned IW   = accumulator_width - 1;
  localparam int unsigned XW   = accumulator_width + 1;
  localparam int unsigned DEVW = sine_lookup_width + 1;
  localparam int unsigned DW   = dwell_width;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_DWELL = 3'd2,
    S_STEP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [IW-1:0]   r_sh_start, r_sh_stop, r_sh_step, r_sh_mod;
  logic [DEVW-1:0] r_sh_dev;
  logic [DW-1:0]   r_sh_dwell;
  logic            r_sh_loop;

  logic [IW-1:0]   r_carrier, r_mod;
  logic [DEVW-1:0] r_dev;
  logic [DW-1:0]   r_step_cnt, r_dwell_cnt;
  logic            r_update, r_busy, r_done;

  logic [IW-1:0]   w_carrier_nxt, w_mod_nxt, w_next_point;
  logic [DEVW-1:0] w_dev_nxt;
  logic [DW-1:0]   w_step_cnt_nxt, w_dwell_cnt_nxt, w_dwell_last, w_step_cnt_inc;
  logic            w_update_nxt, w_busy_nxt, w_done_nxt;
  logic            w_capture, w_dwell_end, w_up, w_last_point, w_clamp;
  logic signed [XW-1:0] w_cur_x, w_stop_x, w_step_x, w_sum_x;

  assign w_capture    = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start && !i_abort;
  assign w_dwell_last = (r_sh_dwell == '0) ? '0 : r_sh_dwell - DW'(1);
  assign w_dwell_end  = i_ce && (r_dwell_cnt == w_dwell_last);
  assign w_up         = $signed(r_sh_start) <= $signed(r_sh_stop);
  assign w_last_point = (r_carrier == r_sh_stop) || (r_sh_step == '0);

  // Two guard bits keep current +/- full-range unsigned step from wrapping before the clamp.
  assign w_cur_x      = {{2{r_carrier[IW-1]}}, r_carrier};
  assign w_stop_x     = {{2{r_sh_stop[IW-1]}}, r_sh_stop};
  assign w_step_x     = {2'b00, r_sh_step};
  assign w_sum_x      = w_up ? (w_cur_x + w_step_x) : (w_cur_x - w_step_x);
  assign w_clamp      = w_up ? (w_sum_x > w_stop_x) : (w_sum_x < w_stop_x);
  assign w_next_point = w_clamp ? r_sh_stop : IW'(w_sum_x);

  assign w_step_cnt_inc = (r_step_cnt == '1) ? r_step_cnt : r_step_cnt + DW'(1);

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // Next-state logic; abort overrides everything except reset
  always_comb begin
    w_next_state = r_state;
    if (i_abort) begin
      w_next_state = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: if (i_start) w_next_state = S_LOAD;
        S_LOAD:         w_next_state = S_DWELL;
        S_DWELL:        if (w_dwell_end) w_next_state = S_STEP;
        S_STEP: begin
          if (!w_last_point) w_next_state = S_DWELL;
          else if (r_sh_loop) w_next_state = S_LOAD;
          else                w_next_state = S_DONE;
        end
        default:        w_next_state = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values
  always_comb begin
    w_carrier_nxt   = r_carrier;
    w_mod_nxt       = r_mod;
    w_dev_nxt       = r_dev;
    w_step_cnt_nxt  = r_step_cnt;
    w_dwell_cnt_nxt = '0;
    w_update_nxt    = 1'b0;
    w_done_nxt      = 1'b0;
    w_busy_nxt      = (w_next_state == S_LOAD) || (w_next_state == S_DWELL) ||
                      (w_next_state == S_STEP);
    if ((r_state == S_DWELL) && (w_next_state == S_DWELL))
      w_dwell_cnt_nxt = r_dwell_cnt + DW'(i_ce);
    unique case (r_state)
      S_LOAD: begin
        if (w_next_state == S_DWELL) begin
          w_carrier_nxt  = r_sh_start;
          w_mod_nxt      = r_sh_mod;
          w_dev_nxt      = r_sh_dev;
          w_step_cnt_nxt = '0;
          w_update_nxt   = 1'b1;
        end
      end
      S_STEP: begin
        if (w_next_state == S_DWELL) begin
          w_carrier_nxt  = w_next_point;
          w_step_cnt_nxt = w_step_cnt_inc;
          w_update_nxt   = 1'b1;
        end
        w_done_nxt = (w_next_state == S_DONE);
      end
      default: ;
    endcase
  end

  // Shadow configuration and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_sh_start  <= '0;
      r_sh_stop   <= '0;
      r_sh_step   <= '0;
      r_sh_mod    <= '0;
      r_sh_dev    <= '0;
      r_sh_dwell  <= '0;
      r_sh_loop   <= 1'b0;
      r_carrier   <= '0;
      r_mod       <= '0;
      r_dev       <= '0;
      r_step_cnt  <= '0;
      r_dwell_cnt <= '0;
      r_update    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (w_capture) begin
        r_sh_start <= i_start_inc;
        r_sh_stop  <= i_stop_inc;
        r_sh_step  <= i_step_inc;
        r_sh_mod   <= i_mod_inc;
        r_sh_dev   <= i_dev;
        r_sh_dwell <= i_dwell;
        r_sh_loop  <= i_loop;
      end
      r_carrier   <= w_carrier_nxt;
      r_mod       <= w_mod_nxt;
      r_dev       <= w_dev_nxt;
      r_step_cnt  <= w_step_cnt_nxt;
      r_dwell_cnt <= w_dwell_cnt_nxt;
      r_update    <= w_update_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  assign o_carrier_center_increment    = r_carrier;
  assign o_modulation_increment        = r_mod;
  assign o_modulation_deviation_amount = r_dev;
  assign o_step_count                  = r_step_cnt;
  assign o_update                      = r_update;
  assign o_busy                        = r_busy;
  assign o_done                        = r_done;

endmodule
